// File: rtl/dsp48_mac_ctrl.sv
// Operand-stream sequencer for a DSP48A1 slice: one multiply-accumulate per frame, result read back from P.
// Define DSP48_MAC_BEATCNT_EN to add the out_beats port (accepted beats per frame).
module dsp48_mac_ctrl #(
    parameter int         N         = 18,
    parameter int         W         = 48,
    parameter int         P_LAT     = 4,
    parameter int         OPM_DLY   = 2,
    parameter logic [7:0] OPM_FIRST = 8'h01,
    parameter logic [7:0] OPM_ACC   = 8'h09,
    parameter int         CNT_W     = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_last,
    output logic [N-1:0] dsp_a,
    output logic [N-1:0] dsp_b,
    output logic [7:0]   dsp_opmode,
    output logic         dsp_ce,
    input  logic [W-1:0] dsp_p,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
`ifdef DSP48_MAC_BEATCNT_EN
    ,
    output logic [CNT_W-1:0] out_beats
`endif
);

    // state | meaning
    // IDLE  | first cycle after reset, slice pipeline not yet advancing
    // ACC   | accepting operand beats of the current frame
    // DRAIN | last beat issued, waiting P_LAT cycles for P to settle
    // HOLD  | result presented, waiting for the consumer handshake
    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DRAIN, ST_HOLD} state_t;

    localparam int             DC_W      = $clog2(P_LAT + 1);
    localparam logic [DC_W-1:0] DRAIN_END = DC_W'(P_LAT);

    state_t          state, state_nxt;
    logic            first_flag;
    logic [DC_W-1:0] drain_cnt;
    logic [7:0]      opm_sr [0:OPM_DLY];
    logic [N-1:0]    slot_a, slot_b;
    logic [7:0]      slot_opm;
    logic            accept, drain_done;

    assign in_ready   = (state == ST_ACC);
    assign accept     = in_valid && in_ready;
    assign drain_done = (state == ST_DRAIN) && (drain_cnt == DRAIN_END);
    // Stage 0 moves in lock-step with dsp_a/dsp_b; the tail lands on OPMODE as the product reaches M.
    assign dsp_opmode = opm_sr[OPM_DLY];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        slot_a    = '0;
        slot_b    = '0;
        slot_opm  = OPM_ACC;
        case (state)
            ST_IDLE:  state_nxt = ST_ACC;
            ST_ACC: begin
                if (accept) begin
                    slot_a   = in_a;
                    slot_b   = in_b;
                    slot_opm = first_flag ? OPM_FIRST : OPM_ACC;
                    if (in_last) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: if (drain_done) state_nxt = ST_HOLD;
            ST_HOLD:  if (out_valid && out_ready) state_nxt = ST_ACC;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dsp_a      <= '0;
            dsp_b      <= '0;
            dsp_ce     <= 1'b0;
            first_flag <= 1'b1;
            drain_cnt  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            for (int i = 0; i <= OPM_DLY; i++) opm_sr[i] <= OPM_ACC;
        end else begin
            dsp_ce <= 1'b1;
            dsp_a  <= slot_a;
            dsp_b  <= slot_b;
            if (state != ST_IDLE) begin
                opm_sr[0] <= slot_opm;
                for (int i = 1; i <= OPM_DLY; i++) opm_sr[i] <= opm_sr[i-1];
            end
            if (accept) first_flag <= in_last;
            if (state == ST_DRAIN) begin
                if (drain_done) begin
                    drain_cnt <= '0;
                    out_data  <= dsp_p;
                    out_valid <= 1'b1;
                end else begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
            end
            if (state == ST_HOLD && out_valid && out_ready) out_valid <= 1'b0;
        end
    end

`ifdef DSP48_MAC_BEATCNT_EN
    logic [CNT_W-1:0] beat_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt  <= '0;
            out_beats <= '0;
        end else begin
            if (accept) begin
                if (first_flag)     beat_cnt <= CNT_W'(1);
                else if (~&beat_cnt) beat_cnt <= beat_cnt + 1'b1;
            end
            if (drain_done) out_beats <= beat_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_dsp48_mac_ctrl.sv
// Bench for dsp48_mac_ctrl: behavioural DSP48A1 slice, directed frames plus randomized frames
// with random bubbles and back-pressure, results checked against per-frame dot products.
module tb_dsp48_mac_ctrl;
    localparam int         N       = 18;
    localparam int         W       = 48;
    localparam int         P_LAT   = 4;
    localparam int         CNT_W   = 16;
    localparam logic [7:0] OPM_ACC = 8'h09;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_a = '0;
    logic [N-1:0] in_b = '0;
    logic         in_last = 1'b0;
    logic [N-1:0] dsp_a, dsp_b;
    logic [7:0]   dsp_opmode;
    logic         dsp_ce;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
`ifdef DSP48_MAC_BEATCNT_EN
    logic [CNT_W-1:0] out_beats;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    bit rdy_rand = 1'b0;
    bit rdy_fix  = 1'b1;

    logic [W-1:0]     exp_q[$];
    int               exp_beats[$];
    logic [N-1:0]     beat_a[$];
    logic [N-1:0]     beat_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slice model: A0/A1 and B0/B1 registers, M register, OPMODE register, P register.
    logic [N-1:0]   s_a0 = '0, s_a1 = '0, s_b0 = '0, s_b1 = '0;
    logic [2*N-1:0] s_m = '0;
    logic [7:0]     s_opm = OPM_ACC;
    logic [W-1:0]   s_p = 48'h0000_00BE_EF01;
    logic [W-1:0]   x_sel, z_sel;

    always_comb begin
        x_sel = (s_opm[1:0] == 2'b01) ? W'(s_m) : '0;
        z_sel = (s_opm[3:2] == 2'b10) ? s_p : '0;
    end

    always @(posedge clk) begin
        if (dsp_ce) begin
            s_a0  <= dsp_a;
            s_a1  <= s_a0;
            s_b0  <= dsp_b;
            s_b1  <= s_b0;
            s_m   <= (2*N)'(s_a1) * (2*N)'(s_b1);
            s_opm <= dsp_opmode;
            s_p   <= x_sel + z_sel;
        end
    end

    dsp48_mac_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .dsp_a      (dsp_a),
        .dsp_b      (dsp_b),
        .dsp_opmode (dsp_opmode),
        .dsp_ce     (dsp_ce),
        .dsp_p      (s_p),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef DSP48_MAC_BEATCNT_EN
        ,
        .out_beats  (out_beats)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    // Output monitor: handshake protocol, hold stability, latency and result values.
    initial begin
        bit           pv, pr;
        logic [W-1:0] pd, ed;
        int           eb;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pv = 1'b0;
                pr = 1'b0;
            end else begin
                if (out_valid) check_val("in_ready_in_hold", 64'(in_ready), 64'd0);
                if (pv && pr) begin
                    check_val("valid_drop", 64'(out_valid), 64'd0);
                    check_val("ready_rise", 64'(in_ready), 64'd1);
                end
                if (pv && !pr) begin
                    check_val("hold_valid", 64'(out_valid), 64'd1);
                    check_val("hold_data", 64'(out_data), 64'(pd));
                end
                if (out_valid && !pv)
                    check_val("result_latency", 64'(cyc - last_acc_cyc), 64'(P_LAT + 1));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_result", 64'(out_valid), 64'd0);
                    end else begin
                        ed = exp_q.pop_front();
                        eb = exp_beats.pop_front();
                        check_val("result_data", 64'(out_data), 64'(ed));
`ifdef DSP48_MAC_BEATCNT_EN
                        check_val("result_beats", 64'(out_beats), 64'(eb));
`endif
                    end
                end
                pv = out_valid;
                pr = out_ready;
                pd = out_data;
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_val("wait_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [N-1:0] a, input logic [N-1:0] b, input logic last,
                             output int acc_cyc);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_val("beat_accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_last  = 1'b0;
    endtask

    // gap < 0 selects a random 0..3 cycle bubble before each non-first beat.
    task automatic send_frame(input int pre_gap, input int gap, input bit expect_res);
        logic [63:0] sum;
        int          acc;
        int          g;
        sum = '0;
        acc = 0;
        wait_ready();
        repeat (pre_gap) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < beat_a.size(); i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            if (i > 0) repeat (g) begin
                @(posedge clk);
                #1;
            end
            sum += 64'(beat_a[i]) * 64'(beat_b[i]);
            send_beat(beat_a[i], beat_b[i], (i == beat_a.size() - 1), acc);
        end
        last_acc_cyc = acc;
        if (expect_res) begin
            exp_q.push_back(sum[W-1:0]);
            exp_beats.push_back(beat_a.size());
        end
    endtask

    task automatic wait_results(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_val("results_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int n;

        // Reset values, then first cycle after release.
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready), 64'd0);
        check_val("rst_dsp_a", 64'(dsp_a), 64'd0);
        check_val("rst_dsp_b", 64'(dsp_b), 64'd0);
        check_val("rst_opmode", 64'(dsp_opmode), 64'(OPM_ACC));
        check_val("rst_dsp_ce", 64'(dsp_ce), 64'd0);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("post_rst_ce", 64'(dsp_ce), 64'd1);
        check_val("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Back-to-back frame.
        beat_a = '{2, 4, 6};
        beat_b = '{3, 5, 7};
        send_frame(0, 0, 1'b1);
        wait_results(50);

        // Bubbles between beats and idle cycles before the first one, P holding a stale result.
        send_frame(3, 2, 1'b1);
        wait_results(50);

        // Consecutive frames: no carry-over from the first.
        beat_a = '{1};
        beat_b = '{1};
        send_frame(0, 0, 1'b1);
        beat_a = '{3, 3};
        beat_b = '{3, 3};
        send_frame(0, 0, 1'b1);
        wait_results(100);

        // Consumer stalls in HOLD for 10 cycles.
        rdy_fix = 1'b0;
        beat_a = '{2, 4, 6};
        beat_b = '{3, 5, 7};
        send_frame(0, 0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("stall_valid_seen", 64'(out_valid), 64'd1);
        repeat (10) begin
            @(negedge clk);
            check_val("stall_valid", 64'(out_valid), 64'd1);
            check_val("stall_in_ready", 64'(in_ready), 64'd0);
        end
        check_val("stall_data", 64'(out_data), 64'd68);
        @(posedge clk);
        #1;
        rdy_fix = 1'b1;
        wait_results(50);

        // Reset pulse during drain discards the frame.
        beat_a = '{5};
        beat_b = '{5};
        send_frame(0, 0, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        check_val("abort_out_valid", 64'(out_valid), 64'd0);
        check_val("abort_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check_val("abort_no_result", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        beat_a = '{2};
        beat_b = '{2};
        send_frame(0, 0, 1'b1);
        wait_results(50);

        // Five unit beats: result and beat count both 5.
        beat_a = '{1, 1, 1, 1, 1};
        beat_b = '{1, 1, 1, 1, 1};
        send_frame(0, 0, 1'b1);
        wait_results(50);

        // Randomized frames with random bubbles and consumer back-pressure.
        rdy_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len = int'($urandom_range(1, 8));
            beat_a.delete();
            beat_b.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    beat_a.push_back(N'($urandom_range(0, (1 << N) - 1)));
                    beat_b.push_back(N'($urandom_range(0, (1 << N) - 1)));
                end else begin
                    beat_a.push_back(N'($urandom_range(0, 15)));
                    beat_b.push_back(N'($urandom_range(0, 15)));
                end
            end
            send_frame(int'($urandom_range(0, 3)), -1, 1'b1);
        end
        rdy_rand = 1'b0;
        rdy_fix  = 1'b1;
        wait_results(800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
